// File: rtl/mult_div_ex.sv
// mult_div_ex: iterative MULT/MULTU/DIV/DIVU unit for the EX stage.
// Owns the HI/LO pair. One bit of the result is produced per clock, so an
// operation occupies the unit for 34 cycles from acceptance to write-back.
//
// Handshake: the unit is ready when `ocupado` is low (state IDLE). A request
// is the single-cycle assertion of `inicio` with `op`/operands valid in the
// same cycle; it is accepted on the rising edge where the unit is IDLE,
// `inicio`=1 and `anular`=0. Requests while busy are dropped, never queued.
// Completion is signalled by the one-cycle `listo` pulse, during which the
// unit is already IDLE and may accept the next request.
module mult_div_ex #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic [1:0]       op,
    input  logic [ANCHO-1:0] operando_a,
    input  logic [ANCHO-1:0] operando_b,
    input  logic             anular,
    output logic [ANCHO-1:0] hi,
    output logic [ANCHO-1:0] lo,
    output logic             ocupado,
    output logic             listo,
    output logic [1:0]       estado
);

    localparam int CW = $clog2(ANCHO);
    localparam logic [CW-1:0] ULTIMA = CW'(ANCHO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } estado_t;

    estado_t            st;
    logic [1:0]         op_q;      // op[1]: divide, op[0]: unsigned
    logic [ANCHO-1:0]   a_q;       // multiplicand / dividend, then quotient
    logic [ANCHO-1:0]   b_q;       // multiplier (shifted out) / divisor
    logic [2*ANCHO-1:0] acc;       // product, or remainder in the low bits
    logic [CW-1:0]      cnt;
    logic               neg_res;
    logic               neg_rem;
    logic               div_cero;

    logic [ANCHO:0]     suma;
    logic [ANCHO:0]     desp;
    logic [ANCHO+1:0]   resta;
    logic               prestamo;
    logic [2*ANCHO-1:0] producto;
    logic [ANCHO-1:0]   cociente;
    logic [ANCHO-1:0]   resto;

    assign ocupado = (st != IDLE);
    assign estado  = st;

    // Datapath for one iteration step and for the final sign fix-up.
    always_comb begin
        suma     = {1'b0, acc[2*ANCHO-1:ANCHO]} + (b_q[0] ? {1'b0, a_q} : '0);
        desp     = {acc[ANCHO-1:0], a_q[ANCHO-1]};
        resta    = {1'b0, desp} - {2'b00, b_q};
        prestamo = resta[ANCHO+1];
        producto = neg_res ? -acc : acc;
        cociente = neg_res ? -a_q : a_q;
        resto    = neg_rem ? -acc[ANCHO-1:0] : acc[ANCHO-1:0];
    end

    // Control FSM and datapath registers; HI/LO written only in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_cero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            listo    <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (st)
                IDLE: begin
                    if (inicio && !anular) begin
                        op_q <= op;
                        a_q  <= operando_a;
                        b_q  <= operando_b;
                        st   <= PREP;
                    end
                end
                PREP: begin
                    if (anular) begin
                        st <= IDLE;
                    end else begin
                        if (!op_q[0]) begin
                            a_q     <= a_q[ANCHO-1] ? -a_q : a_q;
                            b_q     <= b_q[ANCHO-1] ? -b_q : b_q;
                            neg_res <= a_q[ANCHO-1] ^ b_q[ANCHO-1];
                            neg_rem <= a_q[ANCHO-1];
                        end else begin
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                        end
                        div_cero <= (b_q == '0);
                        acc      <= '0;
                        cnt      <= '0;
                        st       <= ITER;
                    end
                end
                ITER: begin
                    if (anular) begin
                        st <= IDLE;
                    end else begin
                        if (op_q[1]) begin
                            // Restoring divide: keep the trial difference unless it borrowed.
                            acc <= {{(ANCHO-1){1'b0}}, (prestamo ? desp : resta[ANCHO:0])};
                            a_q <= {a_q[ANCHO-2:0], ~prestamo};
                        end else begin
                            // Shift-add multiply, multiplier bits consumed LSB first.
                            acc <= {suma, acc[ANCHO-1:1]};
                            b_q <= b_q >> 1;
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == ULTIMA) begin
                            st <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (anular) begin
                        st <= IDLE;
                    end else begin
                        if (op_q[1]) begin
                            // With a zero divisor the remainder path already yields
                            // |a| restored to a; only the quotient must be forced.
                            lo <= div_cero ? '1 : cociente;
                            hi <= resto;
                        end else begin
                            lo <= producto[ANCHO-1:0];
                            hi <= producto[2*ANCHO-1:ANCHO];
                        end
                        listo <= 1'b1;
                        st    <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ex.sv
// tb_mult_div_ex: self-checking bench for mult_div_ex with directed vectors,
// flush/reset scenarios and randomized operations against an arithmetic model.
module tb_mult_div_ex;

  logic        clk;
  logic        reset;
  logic        inicio;
  logic [1:0]  op;
  logic [31:0] operando_a;
  logic [31:0] operando_b;
  logic        anular;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ocupado;
  logic        listo;
  logic [1:0]  estado;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mult_div_ex #(.ANCHO(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .inicio     (inicio),
    .op         (op),
    .operando_a (operando_a),
    .operando_b (operando_b),
    .anular     (anular),
    .hi         (hi),
    .lo         (lo),
    .ocupado    (ocupado),
    .listo      (listo),
    .estado     (estado)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      2'b00: begin
        sq = sa * sb;
        return sq;
      end
      2'b01: begin
        up = ua * ub;
        return up;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      4: return 32'hFFFF_FFF0 | $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Driver: present a request, push its expected result, release after T0.
  // Called #1 after a rising edge; returns #1 after the accepting edge T0.
  task automatic issue_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
    inicio     = 1'b1;
    op         = o;
    operando_a = a;
    operando_b = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    inicio     = 1'b0;
    op         = 2'($urandom);
    operando_a = $urandom;
    operando_b = $urandom;
    check_eq("busy_after_t0", {63'd0, ocupado}, 64'd1);
    check_eq("listo_low_at_t0", {63'd0, listo}, 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue_exp(o, a, b, ref_model(o, a, b));
  endtask

  // Wait for listo, checking latency, busy width, HI/LO hold and result.
  // poke > 0 raises a stray inicio at that cycle for one cycle.
  task automatic wait_done(input int poke);
    int cyc;
    int busy;
    logic [63:0] exp;
    cyc  = 0;
    busy = 1;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke > 0 && cyc == poke) begin
        inicio     = 1'b1;
        op         = 2'($urandom);
        operando_a = $urandom;
        operando_b = $urandom;
      end else if (poke > 0 && cyc == poke + 1) begin
        inicio = 1'b0;
      end
      if (listo) break;
      busy += int'(ocupado);
      if (cyc == 17) check_eq("hold_mid_op", {hi, lo}, {model_hi, model_lo});
    end
    check_eq("latency", 64'(cyc), 64'd34);
    check_eq("busy_cycles", 64'(busy), 64'd34);
    check_eq("idle_at_listo", {63'd0, ocupado}, 64'd0);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq("hi", {32'd0, hi}, {32'd0, exp[63:32]});
      check_eq("lo", {32'd0, lo}, {32'd0, exp[31:0]});
      model_hi = exp[63:32];
      model_lo = exp[31:0];
    end
  endtask

  initial begin
    int cnt_listo;
    logic [1:0] o;
    logic [31:0] a;
    logic [31:0] b;
    int poke;

    reset      = 1'b1;
    inicio     = 1'b0;
    anular     = 1'b0;
    op         = 2'b00;
    operando_a = '0;
    operando_b = '0;
    model_hi   = '0;
    model_lo   = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_ocupado", {63'd0, ocupado}, 64'd0);
    check_eq("rst_listo", {63'd0, listo}, 64'd0);
    check_eq("rst_estado", {62'd0, estado}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results.
    issue_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001); wait_done(0);
    issue_exp(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB); wait_done(0);
    issue_exp(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000); wait_done(0);
    issue_exp(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD); wait_done(0);
    issue_exp(2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E); wait_done(0);
    issue_exp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000); wait_done(0);
    issue_exp(2'b11, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF); wait_done(0);
    issue_exp(2'b10, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF); wait_done(0);
    issue_exp(2'b10, 32'h8000_0001, 32'h0000_0000, 64'h8000_0001_FFFF_FFFF); wait_done(0);

    // MULTU 3x5 with a stray inicio mid-ITER, then DIV 9/2 issued in the
    // listo cycle and flushed; HI/LO must stay 0/15.
    issue_exp(2'b01, 32'd3, 32'd5, 64'd15); wait_done(6);
    issue_exp(2'b10, 32'd9, 32'd2, 64'h0000_0001_0000_0004);
    repeat (10) @(posedge clk);
    #1;
    anular = 1'b1;
    @(posedge clk);
    #1;
    anular = 1'b0;
    check_eq("flush_ocupado", {63'd0, ocupado}, 64'd0);
    check_eq("flush_estado", {62'd0, estado}, 64'd0);
    void'(exp_q.pop_front());
    cnt_listo = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      cnt_listo += int'(listo);
    end
    check_eq("flush_no_listo", 64'(cnt_listo), 64'd0);
    check_eq("flush_hilo", {hi, lo}, 64'd15);

    // anular together with inicio in IDLE: request is not taken.
    inicio = 1'b1;
    anular = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    anular = 1'b0;
    check_eq("anular_wins", {63'd0, ocupado}, 64'd0);

    // Randomized operations, mostly back-to-back.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = pick_operand();
      b = pick_operand();
      poke = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      issue(o, a, b);
      wait_done(poke);
      if (poke > 0 || $urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
        check_eq("no_queue", {63'd0, ocupado}, 64'd0);
        check_eq("listo_one_cycle", {63'd0, listo}, 64'd0);
      end
    end

    // Asynchronous reset mid-ITER with HI/LO holding a nonzero value.
    issue_exp(2'b01, 32'd1234, 32'd5678, 64'd7006652); wait_done(0);
    issue(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (12) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_rst_hilo", {hi, lo}, 64'd0);
    check_eq("async_rst_ocupado", {63'd0, ocupado}, 64'd0);
    check_eq("async_rst_listo", {63'd0, listo}, 64'd0);
    exp_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue_exp(2'b01, 32'd2, 32'd3, 64'd6); wait_done(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
